decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 39 +++
 rtl/decode_skid.sv | 71 +++++++
 rtl/decode_stage.sv | 71 +++++++
 tb/tb_decode_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared widths, the R-type opcode and the decoded-bundle struct for the decode stage,
// plus the combinational field-extraction function.
package decode_pkg;

  localparam int DEC_INST_W  = 16;
  localparam int DEC_OP_W    = 4;
  localparam int DEC_REG_W   = 4;
  localparam int DEC_ADDR_W  = 8;
  localparam int DEC_NUM_OPS = 16;
  localparam logic [DEC_OP_W-1:0] DEC_RTYPE_OP = 4'b0011;

  typedef struct packed {
    logic [DEC_OP_W-1:0]   op;
    logic [DEC_REG_W-1:0]  reg0;
    logic [DEC_REG_W-1:0]  reg1;
    logic [DEC_REG_W-1:0]  reg2;
    logic [DEC_ADDR_W-1:0] addr;
    logic                  rtype;
    logic                  illegal;
  } dec_bundle_t;

  // illegal is left 0 here; the top fills it in when the check is built
  function automatic dec_bundle_t decode_fields(input logic [DEC_INST_W-1:0] inst,
                                                input logic [DEC_OP_W-1:0]   rtype_op);
    dec_bundle_t b;
    b      = '0;
    b.op   = inst[DEC_INST_W-1 -: DEC_OP_W];
    b.reg0 = inst[DEC_ADDR_W +: DEC_REG_W];
    if (b.op == rtype_op) begin
      b.reg1  = inst[2*DEC_REG_W-1:DEC_REG_W];
      b.reg2  = inst[DEC_REG_W-1:0];
      b.rtype = 1'b1;
    end else begin
      b.addr = inst[DEC_ADDR_W-1:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/decode_skid.sv
// Two-entry buffer (output register + skid entry) with registered in_ready,
// full throughput, flush and synchronous active-high reset.
module decode_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] out_q, out_d, skid_q, skid_d;
  logic         out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, in_rdy_q, in_rdy_d;
  logic         acc, drn;

  assign acc = in_valid && in_rdy_q;
  assign drn = out_vld_q && out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || drn) begin
      // output slot frees up: skid has priority; acc cannot coincide with a full skid
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_d     = in_data;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (acc) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_q;

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field extraction feeding a two-entry skid buffer.
// Define DECODE_ILLEGAL_EN to flag opcodes >= NUM_OPS on the illegal output.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INST_W  = DEC_INST_W,
  parameter int OP_W    = DEC_OP_W,
  parameter int REG_W   = DEC_REG_W,
  parameter int ADDR_W  = DEC_ADDR_W,
  parameter logic [DEC_OP_W-1:0] RTYPE_OP = DEC_RTYPE_OP,
  parameter int NUM_OPS = DEC_NUM_OPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   op,
  output logic [REG_W-1:0]  reg0,
  output logic [REG_W-1:0]  reg1,
  output logic [REG_W-1:0]  reg2,
  output logic [ADDR_W-1:0] addr,
  output logic              rtype,
  output logic              illegal
);

  if (INST_W != OP_W + REG_W + ADDR_W || ADDR_W < 2 * REG_W) begin : g_bad_fields
    $error("decode_stage: INST_W must equal OP_W+REG_W+ADDR_W and ADDR_W >= 2*REG_W");
  end
  // the bundle struct is sized from the package, so the widths must match it
  if (OP_W != DEC_OP_W || REG_W != DEC_REG_W || ADDR_W != DEC_ADDR_W) begin : g_bad_pkg
    $error("decode_stage: field widths must match decode_pkg");
  end

  dec_bundle_t dec_in, dec_out;

  always_comb begin
    dec_in = decode_fields(inst, RTYPE_OP);
`ifdef DECODE_ILLEGAL_EN
    dec_in.illegal = (32'(dec_in.op) >= NUM_OPS);
`endif
  end

  decode_skid #(.W($bits(dec_bundle_t))) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (dec_out)
  );

  assign op    = dec_out.op;
  assign reg0  = dec_out.reg0;
  assign reg1  = dec_out.reg1;
  assign reg2  = dec_out.reg2;
  assign addr  = dec_out.addr;
  assign rtype = dec_out.rtype;
`ifdef DECODE_ILLEGAL_EN
  assign illegal = dec_out.illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases plus randomized traffic against
// an arithmetic reference model; built with NUM_OPS=8.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] inst;
  logic        in_ready, out_valid, rtype, illegal;
  logic [3:0]  op, reg0, reg1, reg2;
  logic [7:0]  addr;

  int errors = 0;
  int checks = 0;
  int popped = 0;

  typedef struct {
    int op, reg0, reg1, reg2, addr, rtype, ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  decode_stage #(.NUM_OPS(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready), .op(op), .reg0(reg0),
    .reg1(reg1), .reg2(reg2), .addr(addr), .rtype(rtype), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  function automatic exp_t model(input int i);
    exp_t e;
    e.op   = (i / 4096) % 16;
    e.reg0 = (i / 256) % 16;
    if (e.op == 3) begin
      e.reg1 = (i / 16) % 16; e.reg2 = i % 16; e.addr = 0; e.rtype = 1;
    end else begin
      e.reg1 = 0; e.reg2 = 0; e.addr = i % 256; e.rtype = 0;
    end
    e.ill = (ILL_EN && e.op >= 8) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare the presented bundle against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_bundle", 1, 0);
      end else begin
        mon_e = sb[0];
        chk("op", int'(op), mon_e.op);
        chk("reg0", int'(reg0), mon_e.reg0);
        chk("reg1", int'(reg1), mon_e.reg1);
        chk("reg2", int'(reg2), mon_e.reg2);
        chk("addr", int'(addr), mon_e.addr);
        chk("rtype", int'(rtype), mon_e.rtype);
        chk("illegal", int'(illegal), mon_e.ill);
        if (out_ready && !flush) begin
          void'(sb.pop_front());
          popped++;
        end
      end
    end
  end

  // expected-response capture, ordered after the monitor within the same half-cycle
  always @(negedge clk) begin
    #1;
    if (rst || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(int'(inst)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    in_valid = 1'b1; inst = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_zero_fields(input string name);
    chk({name, "_fields"}, int'({op, reg0, reg1, reg2, addr, rtype, illegal}), 0);
  endtask

  int bubbles, p0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0;
    step(); step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk_zero_fields("rst");
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", int'(in_ready), 1);

    // R-type and immediate-form decode, 1-cycle latency
    out_ready = 1'b1;
    push(16'h3A5C);
    chk("rtype_latency_valid", int'(out_valid), 1);
    step();
    push(16'h1B42);
    chk("imm_latency_valid", int'(out_valid), 1);
    step();
    chk("idle_valid", int'(out_valid), 0);

    // stall: second push lands in skid, then both drain on consecutive cycles
    out_ready = 1'b0;
    push(16'h1001);
    push(16'h2002);
    chk("stall_in_ready", int'(in_ready), 0);
    step();
    chk("stall_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    step();
    chk("drain_second_valid", int'(out_valid), 1);
    chk("drain_in_ready", int'(in_ready), 1);
    step();
    chk("drain_done_valid", int'(out_valid), 0);

    // flush with skid full and an instruction offered
    out_ready = 1'b0;
    push(16'hA001);
    push(16'hB002);
    flush = 1'b1; in_valid = 1'b1; inst = 16'hC003;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    step(); step();
    chk("flush_nothing_emitted", int'(out_valid), 0);

    // opcode above NUM_OPS
    push(16'h9000);
    chk("illegal_op_valid", int'(out_valid), 1);
    step();

    // reset while two bundles are held
    out_ready = 1'b0;
    push(16'h4111);
    push(16'h5222);
    rst = 1'b1;
    step();
    chk("midstall_rst_valid", int'(out_valid), 0);
    chk("midstall_rst_in_ready", int'(in_ready), 0);
    chk_zero_fields("midstall_rst");
    rst = 1'b0;
    step();

    // 100 back-to-back transfers with no bubbles
    out_ready = 1'b1; bubbles = 0; p0 = popped;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      inst = 16'($urandom);
      step();
      if (!out_valid || !in_ready) bubbles++;
    end
    in_valid = 1'b0;
    step();
    chk("stream_bubbles", bubbles, 0);
    chk("stream_count", popped - p0, 100);

    // randomized traffic with occasional flush and reset
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      inst      = 16'($urandom);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("final_queue_empty", sb.size(), 0);
    chk("final_out_valid", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
